even_count_monitor: RTL and testbench

- Receive-side checker for the sample stream from the even up/down counter: takes a sampled counter value each strobe and tracks it.
- Infers count direction and verifies each step is a legal 0/+2/-2 move modulo 2^N. Flags parity and step errors and detects wrap-around.
- Reports lock once the stream is consistently legal.
- Sits on the far side of a counter output bus for self-checking and debug.

---
 rtl/even_count_monitor.sv | 234 +++++++++++++++++++++++
 tb/tb_even_count_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/even_count_monitor.sv
// ---------------------------------------------------------------------------
// even_count_monitor
//
// Purpose:
//   Receive-side checker for the sample stream of an even up/down counter.
//   Each strobe the sampled counter value is compared with the last accepted
//   even value. A legal move is 0 (hold), +2 (up) or -2 (down) modulo 2^N.
//   The block infers the count direction and flags odd values (parity) and
//   illegal steps. It pulses on wrap-around across 2^N-2 <-> 0, counts errors
//   with saturation, and reports lock after LOCK_LEN consecutive legal moving
//   steps.
//
// Parameters:
//   N        width of the monitored counter value (N >= 3)
//   LOCK_LEN legal moving steps needed before locked_o rises (1..15)
//   ERR_W    width of the saturating error counter
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous reset, active low
//   sample_i      din_i is valid this cycle
//   din_i         counter value being monitored
//   clear_i       synchronous clear of tracking state and error count
//   dir_o         inferred direction, 1 = up, 0 = down (valid when dir_valid_o)
//   dir_valid_o   a moving step has been seen since the last (re)sync
//   locked_o      LOCK_LEN consecutive legal moving steps seen
//   step_err_o    one-cycle pulse: illegal step
//   parity_err_o  one-cycle pulse: odd din_i
//   wrap_pulse_o  one-cycle pulse: legal step crossed 2^N-2 <-> 0
//   err_count_o   errors since reset/clear, saturates at all-ones
//   last_o        last accepted even value
// ---------------------------------------------------------------------------
module even_count_monitor #(
  parameter int N        = 4,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_i,
  input  logic [N-1:0]     din_i,
  input  logic             clear_i,
  output logic             dir_o,
  output logic             dir_valid_o,
  output logic             locked_o,
  output logic             step_err_o,
  output logic             parity_err_o,
  output logic             wrap_pulse_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [N-1:0]     last_o
);

  // LOCK_LEN is at most 15, so a 4-bit run counter always suffices.
  localparam int             RUN_W    = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_LEN);

  // Delta of an up step, and the largest even value 2^N-2, which is also the
  // delta of a down step (-2 mod 2^N).
  localparam logic [N-1:0] STEP_UP  = N'(2);
  localparam logic [N-1:0] TOP_EVEN = {{(N-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,  // no reference value held
    S_PRIMED = 2'd1,  // reference held, direction unknown
    S_TRACK  = 2'd2   // reference held, direction known
  } state_e;

  state_e state_q, state_d;

  logic [N-1:0]     last_q, last_d;
  logic             dir_q, dir_d;
  logic             dir_valid_q, dir_valid_d;
  logic             locked_q, locked_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             step_err_q, step_err_d;
  logic             parity_err_q, parity_err_d;
  logic             wrap_q, wrap_d;

  // -------------------------------------------------------------------------
  // Step classification against the held reference
  // -------------------------------------------------------------------------
  logic [N-1:0]     delta;
  logic             is_odd;
  logic             is_hold;
  logic             is_up;
  logic             is_down;
  logic             is_move;
  logic             have_ref;
  logic             wrap_hit;
  logic [RUN_W-1:0] run_inc;
  logic [ERR_W-1:0] err_inc;

  always_comb begin
    delta    = din_i - last_q;  // wraps modulo 2^N by width
    is_odd   = din_i[0];
    is_hold  = (delta == '0);
    is_up    = (delta == STEP_UP);
    is_down  = (delta == TOP_EVEN);
    is_move  = is_up | is_down;
    have_ref = (state_q != S_EMPTY);

    // A legal move only crosses the boundary in these two exact cases.
    wrap_hit = (is_up   && (last_q == TOP_EVEN) && (din_i == '0)) ||
               (is_down && (last_q == '0)       && (din_i == TOP_EVEN));

    run_inc  = (run_q >= RUN_MAX) ? run_q : run_q + RUN_W'(1);
    err_inc  = (&err_count_q) ? err_count_q : err_count_q + ERR_W'(1);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_EMPTY;
    end else if (sample_i) begin
      if (is_odd) begin
        // Parity error drops the reference regardless of the current state.
        state_d = S_EMPTY;
      end else if (!have_ref) begin
        state_d = S_PRIMED;
      end else if (is_move) begin
        state_d = S_TRACK;
      end else if (!is_hold) begin
        // Illegal step: resync on the new value, direction unknown again.
        state_d = S_PRIMED;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output / datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    last_d       = last_q;
    dir_d        = dir_q;
    dir_valid_d  = dir_valid_q;
    locked_d     = locked_q;
    run_d        = run_q;
    err_count_d  = err_count_q;
    step_err_d   = 1'b0;
    parity_err_d = 1'b0;
    wrap_d       = 1'b0;

    if (clear_i) begin
      // Clear wins over a same-cycle sample; no pulses are produced.
      last_d      = '0;
      dir_d       = 1'b0;
      dir_valid_d = 1'b0;
      locked_d    = 1'b0;
      run_d       = '0;
      err_count_d = '0;
    end else if (sample_i) begin
      if (is_odd) begin
        // Parity takes precedence over step classification. last_q is kept
        // but stops being a reference because the state returns to EMPTY.
        parity_err_d = 1'b1;
        err_count_d  = err_inc;
        dir_valid_d  = 1'b0;
        locked_d     = 1'b0;
        run_d        = '0;
      end else if (!have_ref) begin
        last_d = din_i;
      end else if (is_hold) begin
        // Hold: nothing moves, lock status is retained.
      end else if (is_move) begin
        // Reversals are legal and keep accumulating the run.
        last_d      = din_i;
        dir_d       = is_up;
        dir_valid_d = 1'b1;
        run_d       = run_inc;
        locked_d    = (run_inc >= RUN_MAX);
        wrap_d      = wrap_hit;
      end else begin
        step_err_d  = 1'b1;
        err_count_d = err_inc;
        last_d      = din_i;
        dir_valid_d = 1'b0;
        locked_d    = 1'b0;
        run_d       = '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath / output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q       <= '0;
      dir_q        <= 1'b0;
      dir_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      run_q        <= '0;
      err_count_q  <= '0;
      step_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      last_q       <= last_d;
      dir_q        <= dir_d;
      dir_valid_q  <= dir_valid_d;
      locked_q     <= locked_d;
      run_q        <= run_d;
      err_count_q  <= err_count_d;
      step_err_q   <= step_err_d;
      parity_err_q <= parity_err_d;
      wrap_q       <= wrap_d;
    end
  end

  assign dir_o        = dir_q;
  assign dir_valid_o  = dir_valid_q;
  assign locked_o     = locked_q;
  assign step_err_o   = step_err_q;
  assign parity_err_o = parity_err_q;
  assign wrap_pulse_o = wrap_q;
  assign err_count_o  = err_count_q;
  assign last_o       = last_q;

endmodule

// File: tb/tb_even_count_monitor.sv
// ---------------------------------------------------------------------------
// tb_even_count_monitor
//
// Self-checking bench for even_count_monitor (N=4, LOCK_LEN=3, ERR_W=3).
// Directed sequences followed by biased random stimulus. Every cycle the DUT
// outputs are compared with a behavioural model of the monitoring rules.
// ---------------------------------------------------------------------------
module tb_even_count_monitor;

  localparam int N        = 4;
  localparam int LOCK_LEN = 3;
  localparam int ERR_W    = 3;
  localparam int MOD      = 1 << N;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             sample;
  logic             clear;
  logic [N-1:0]     din;
  logic             dir;
  logic             dir_valid;
  logic             locked;
  logic             step_err;
  logic             parity_err;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;
  logic [N-1:0]     last;

  even_count_monitor #(
    .N(N),
    .LOCK_LEN(LOCK_LEN),
    .ERR_W(ERR_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .sample_i(sample),
    .din_i(din),
    .clear_i(clear),
    .dir_o(dir),
    .dir_valid_o(dir_valid),
    .locked_o(locked),
    .step_err_o(step_err),
    .parity_err_o(parity_err),
    .wrap_pulse_o(wrap_pulse),
    .err_count_o(err_count),
    .last_o(last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_has_ref;
  int m_last;
  bit m_dir;
  bit m_dv;
  bit m_lk;
  int m_run;
  int m_errs;
  bit m_step;
  bit m_par;
  bit m_wrap;

  task automatic model_reset();
    m_has_ref = 0; m_last = 0; m_dir = 0; m_dv = 0; m_lk = 0;
    m_run = 0; m_errs = 0; m_step = 0; m_par = 0; m_wrap = 0;
  endtask

  task automatic model_apply(input bit s, input bit c, input int d);
    int delta;
    m_step = 0; m_par = 0; m_wrap = 0;
    if (c) begin
      model_reset();
      return;
    end
    if (!s) return;
    if (d % 2 == 1) begin
      m_par  = 1;
      m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
      m_has_ref = 0; m_dv = 0; m_lk = 0; m_run = 0;
      return;
    end
    if (!m_has_ref) begin
      m_has_ref = 1;
      m_last    = d;
      return;
    end
    delta = (d - m_last + MOD) % MOD;
    if (delta == 0) return;
    if (delta == 2 || delta == MOD - 2) begin
      // Going up yet landing lower (or down yet landing higher) means wrap.
      m_wrap = (delta == 2) ? (d < m_last) : (d > m_last);
      m_dir  = (delta == 2);
      m_dv   = 1;
      m_last = d;
      m_run  = (m_run + 1 > LOCK_LEN) ? LOCK_LEN : m_run + 1;
      if (m_run == LOCK_LEN) m_lk = 1;
    end else begin
      m_step = 1;
      m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
      m_last = d;
      m_dv = 0; m_lk = 0; m_run = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".last"},      32'(last),       32'(m_last));
    check({ctx, ".dir"},       32'(dir),        32'(m_dir));
    check({ctx, ".dir_valid"}, 32'(dir_valid),  32'(m_dv));
    check({ctx, ".locked"},    32'(locked),     32'(m_lk));
    check({ctx, ".step_err"},  32'(step_err),   32'(m_step));
    check({ctx, ".parity"},    32'(parity_err), 32'(m_par));
    check({ctx, ".wrap"},      32'(wrap_pulse), 32'(m_wrap));
    check({ctx, ".err_count"}, 32'(err_count),  32'(m_errs));
  endtask

  task automatic step(input bit s, input bit c, input int d, input string ctx);
    @(negedge clk);
    sample = s;
    clear  = c;
    din    = N'(d);
    model_apply(s, c, d);
    @(posedge clk);
    #1;
    check_all(ctx);
    $display("%-10s s=%0b c=%0b din=%0d -> last=%0d dir=%0b dv=%0b lk=%0b se=%0b pe=%0b wr=%0b ec=%0d",
             ctx, s, c, d, last, dir, dir_valid, locked, step_err, parity_err,
             wrap_pulse, err_count);
  endtask

  initial begin
    int r;
    int d;
    bit s;
    bit c;

    rst_n = 1'b0; sample = 1'b0; clear = 1'b0; din = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Count up from 0 and lock
    step(1, 0, 0, "up0");
    step(1, 0, 2, "up2");
    check("up2.dir_valid_const", 32'(dir_valid), 32'd1);
    check("up2.dir_const", 32'(dir), 32'd1);
    step(1, 0, 4, "up4");
    check("up4.locked_const", 32'(locked), 32'd0);
    step(1, 0, 6, "up6");
    check("up6.locked_const", 32'(locked), 32'd1);
    step(0, 0, 9, "idle");

    // Up wrap then down wrap
    step(0, 1, 0, "clr");
    step(1, 0, 12, "uw12");
    step(1, 0, 14, "uw14");
    check("uw14.wrap_const", 32'(wrap_pulse), 32'd0);
    step(1, 0, 0, "uw0");
    check("uw0.wrap_const", 32'(wrap_pulse), 32'd1);
    step(1, 0, 2, "uw2");
    check("uw2.wrap_const", 32'(wrap_pulse), 32'd0);
    step(1, 0, 0, "dw0");
    step(1, 0, 14, "dw14");
    check("dw14.wrap_const", 32'(wrap_pulse), 32'd1);
    check("dw14.dir_const", 32'(dir), 32'd0);
    check("dw14.err_const", 32'(err_count), 32'd0);

    // Holds and reversal
    step(0, 1, 0, "clr");
    step(1, 0, 4, "h4");
    step(1, 0, 6, "h6");
    step(1, 0, 6, "h6b");
    step(1, 0, 6, "h6c");
    step(1, 0, 8, "h8");
    step(1, 0, 6, "rev6");
    check("rev6.locked_const", 32'(locked), 32'd1);
    check("rev6.dir_const", 32'(dir), 32'd0);
    step(1, 0, 6, "hold_lk");
    check("hold_lk.locked_const", 32'(locked), 32'd1);

    // Step error and resync
    step(0, 1, 0, "clr");
    step(1, 0, 4, "se4");
    step(1, 0, 6, "se6");
    step(1, 0, 10, "se10");
    check("se10.step_const", 32'(step_err), 32'd1);
    check("se10.last_const", 32'(last), 32'd10);
    check("se10.err_const", 32'(err_count), 32'd1);
    step(1, 0, 12, "se12");
    check("se12.dv_const", 32'(dir_valid), 32'd1);

    // Parity errors
    step(0, 1, 0, "clr");
    step(1, 0, 4, "pe4");
    step(1, 0, 5, "pe5");
    check("pe5.parity_const", 32'(parity_err), 32'd1);
    check("pe5.step_const", 32'(step_err), 32'd0);
    step(1, 0, 6, "pe6");
    check("pe6.dv_const", 32'(dir_valid), 32'd0);
    step(1, 0, 7, "pe7");
    check("pe7.err_const", 32'(err_count), 32'd2);

    // Error counter saturation, then clear with a same-cycle sample
    step(0, 1, 0, "clr");
    for (int i = 0; i < ERR_MAX + 2; i++) step(1, 0, 2 * i + 1, "sat");
    check("sat.err_const", 32'(err_count), 32'(ERR_MAX));
    step(1, 1, 2, "clr_s");
    check("clr_s.last_const", 32'(last), 32'd0);
    check("clr_s.err_const", 32'(err_count), 32'd0);

    // Asynchronous reset mid-stream
    step(1, 0, 0, "ar0");
    step(1, 0, 2, "ar2");
    step(1, 0, 4, "ar4");
    step(1, 0, 6, "ar6");
    @(negedge clk);
    #2;
    sample = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.locked_const", 32'(locked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8, "post_rst");
    check("post_rst.dv_const", 32'(dir_valid), 32'd0);

    // Biased random stream
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        case ($urandom_range(0, 2))
          0:       d = m_last;
          1:       d = (m_last + 2) % MOD;
          default: d = (m_last + MOD - 2) % MOD;
        endcase
      end else if (r < 85) begin
        d = 2 * $urandom_range(0, MOD / 2 - 1);
      end else begin
        d = $urandom_range(0, MOD - 1);
      end
      s = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 39) == 0);
      step(s, c, d, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
